// File: rtl/apple_kb_latch.sv
// apple_kb_latch
//
// CPU-side keyboard responder for the USB keyboard path. A raw HID usage code
// from the keyboard PIO is synchronized and debounced, then translated into
// Apple IIe keyboard semantics: a 7-bit ASCII latch, the keyboard strobe, the
// any-key-down flag and (optionally) typematic repeat. The latch is presented
// on the 6502 soft switches KBD ($C000-$C00F) and KBDSTRB ($C010-$C01F).
//
// Build option:
//   KB_REPEAT_EN  - when defined, a held key re-sets the strobe after
//                   REPEAT_DELAY_CYCLES and then every REPEAT_PERIOD_CYCLES.
//                   When undefined, the repeat counter and REPEAT state are
//                   not built and a held key sets the strobe exactly once.
//
// Ports:
//   clk      in   system clock (50 MHz domain)
//   reset    in   asynchronous active-high reset
//   keycode  in   [7:0] HID usage code, 0x00 = no key, asynchronous to clk
//   bus_en   in   one-clk pulse marking the valid address/rw phase of a cycle
//   addr     in   [15:0] CPU address bus
//   rw       in   1 = read, 0 = write
//   dbo      out  [7:0] read data toward the CPU
//   sel      out  high when dbo must drive the CPU data bus

module apple_kb_latch #(
  parameter int unsigned STABLE_CYCLES        = 50000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 3333333
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  keycode,
  input  logic        bus_en,
  input  logic [15:0] addr,
  input  logic        rw,
  output logic [7:0]  dbo,
  output logic        sel
);

  // --------------------------------------------------------------------------
  // Counter sizing
  // --------------------------------------------------------------------------
  localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
  localparam logic [StabW-1:0] StabMax  = StabW'(STABLE_CYCLES);
  localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);

`ifdef KB_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                   REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned RptW = $clog2(RptMax + 1);
  localparam logic [RptW-1:0] RptSat     = RptW'(RptMax);
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_e;
`else
  // Repeat timing is not built; keep the parameters referenced.
  localparam int unsigned unused_rpt = REPEAT_DELAY_CYCLES + REPEAT_PERIOD_CYCLES;

  typedef enum logic [0:0] {StIdle, StHeld} state_e;
`endif

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [7:0]       kc_m_q;             // first synchronizer stage
  logic [7:0]       kc_s_q;             // synchronized keycode
  logic [7:0]       kc_st_q, kc_st_d;   // last debounced keycode
  logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
  logic [6:0]       ascii_q, ascii_d;
  logic             strobe_q, strobe_d;
  logic             akd_q, akd_d;
`ifdef KB_REPEAT_EN
  logic [RptW-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic [RptW-1:0]  rpt_inc;
`endif

  logic             kc_valid;
  logic             key_new;
  logic             key_release;
  logic             strobe_set;
  logic             strobe_clr;
  logic             xl_hit;
  logic [6:0]       xl_ascii;
  logic             kbd_hit;
  logic             strb_hit;
  logic             unused_addr;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  // The counter reloads whenever kc_s is about to change, so kc_valid fires
  // once, on the edge where an unchanged kc_s completes STABLE_CYCLES clocks.
  // The FSM acts on kc_s in that same cycle (the value kc_st is latching).
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (kc_m_q != kc_s_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != StabMax) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
  end

  assign kc_valid = (stab_cnt_q == StabLast) && (kc_m_q == kc_s_q);
  assign kc_st_d  = kc_valid ? kc_s_q : kc_st_q;

  // --------------------------------------------------------------------------
  // HID usage -> ASCII
  // --------------------------------------------------------------------------
  always_comb begin
    xl_hit   = 1'b1;
    xl_ascii = 7'h00;
    if (kc_s_q >= 8'h04 && kc_s_q <= 8'h1D) begin
      xl_ascii = 7'(kc_s_q + 8'h3D);        // letters A-Z
    end else if (kc_s_q >= 8'h1E && kc_s_q <= 8'h26) begin
      xl_ascii = 7'(kc_s_q + 8'h13);        // digits 1-9
    end else begin
      case (kc_s_q)
        8'h27:   xl_ascii = 7'h30;          // 0
        8'h28:   xl_ascii = 7'h0D;          // return
        8'h29:   xl_ascii = 7'h1B;          // escape
        8'h2A:   xl_ascii = 7'h08;          // backspace -> left arrow
        8'h2B:   xl_ascii = 7'h09;          // tab
        8'h2C:   xl_ascii = 7'h20;          // space
        8'h4F:   xl_ascii = 7'h15;          // right arrow
        8'h50:   xl_ascii = 7'h08;          // left arrow
        8'h51:   xl_ascii = 7'h0A;          // down arrow
        8'h52:   xl_ascii = 7'h0B;          // up arrow
        default: xl_hit   = 1'b0;
      endcase
    end
  end

  // A fresh press is any mapped code from idle, or a mapped code that differs
  // from the one already held (rollover). Code 0x00 is never mapped.
  assign key_new     = kc_valid && xl_hit && ((state_q == StIdle) || (kc_s_q != kc_st_q));
  assign key_release = kc_valid && (kc_s_q == 8'h00);

  // --------------------------------------------------------------------------
  // Key FSM
  // --------------------------------------------------------------------------
`ifdef KB_REPEAT_EN
  assign rpt_inc = (rpt_cnt_q == RptSat) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ascii_d    = ascii_q;
    akd_d      = akd_q;
    strobe_set = 1'b0;
`ifdef KB_REPEAT_EN
    rpt_cnt_d  = (state_q == StIdle) ? '0 : rpt_inc;
`endif

    if (key_new) begin
      // Press and rollover behave identically from every state.
      state_d    = StHeld;
      ascii_d    = xl_ascii;
      akd_d      = 1'b1;
      strobe_set = 1'b1;
`ifdef KB_REPEAT_EN
      rpt_cnt_d  = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StHeld: begin
          if (key_release) begin
            akd_d   = 1'b0;
            state_d = StIdle;
`ifdef KB_REPEAT_EN
          end else if (rpt_cnt_q == DelayLast) begin
            strobe_set = 1'b1;
            rpt_cnt_d  = '0;
            state_d    = StRepeat;
`endif
          end
        end
`ifdef KB_REPEAT_EN
        StRepeat: begin
          if (key_release) begin
            akd_d   = 1'b0;
            state_d = StIdle;
          end else if (rpt_cnt_q == PeriodLast) begin
            strobe_set = 1'b1;
            rpt_cnt_d  = '0;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // Set beats clear so a keypress landing on a KBDSTRB access is never lost.
  assign strobe_d = strobe_set | (strobe_q & ~strobe_clr);

  // --------------------------------------------------------------------------
  // CPU bus
  // --------------------------------------------------------------------------
  assign kbd_hit     = (addr[15:4] == 12'hC00);
  assign strb_hit    = (addr[15:4] == 12'hC01);
  assign strobe_clr  = bus_en && strb_hit;
  assign unused_addr = ^addr[3:0];

  // Reads see the pre-clear register values. Outputs are held quiet during
  // reset so the bus is released without waiting for a clock edge.
  always_comb begin
    sel = 1'b0;
    dbo = 8'h00;
    if (!reset && rw) begin
      if (kbd_hit) begin
        sel = 1'b1;
        dbo = {strobe_q, ascii_q};
      end else if (strb_hit) begin
        sel = 1'b1;
        dbo = {akd_q, ascii_q};
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kc_m_q     <= 8'h00;
      kc_s_q     <= 8'h00;
      kc_st_q    <= 8'h00;
      stab_cnt_q <= '0;
      state_q    <= StIdle;
      ascii_q    <= 7'h00;
      strobe_q   <= 1'b0;
      akd_q      <= 1'b0;
`ifdef KB_REPEAT_EN
      rpt_cnt_q  <= '0;
`endif
    end else begin
      kc_m_q     <= keycode;
      kc_s_q     <= kc_m_q;
      kc_st_q    <= kc_st_d;
      stab_cnt_q <= stab_cnt_d;
      state_q    <= state_d;
      ascii_q    <= ascii_d;
      strobe_q   <= strobe_d;
      akd_q      <= akd_d;
`ifdef KB_REPEAT_EN
      rpt_cnt_q  <= rpt_cnt_d;
`endif
    end
  end

endmodule

// File: doc/apple_kb_latch.md
Name: apple_kb_latch

Overview:
- CPU-side responder for the USB keyboard path.
- Takes the raw HID usage code from the keyboard subsystem's keycode PIO and turns it into Apple IIe keyboard semantics: 7-bit ASCII latch, keyboard strobe, any-key-down flag and typematic repeat.
- Serves the 6502 soft switches KBD ($C000–$C00F) and KBDSTRB ($C010–$C01F) on the CPU bus.

Parameters:
- STABLE_CYCLES, 50000: clocks a synchronized keycode must hold unchanged before it is acted on (1 ms at 50 MHz).
- REPEAT_DELAY_CYCLES, 25000000: clocks from first acceptance to first repeat (500 ms).
- REPEAT_PERIOD_CYCLES, 3333333: clocks between subsequent repeats (~15 Hz).

Ports:
- clk, in, 1: system clock, MAX10_CLK1_50 domain.
- reset, in, 1: asynchronous, active-high reset.
- keycode, in, 8: HID usage code from the keyboard PIO; 0x00 means no key. Asynchronous to clk.
- bus_en, in, 1: one-clk pulse marking the valid address/rw phase of a CPU bus cycle.
- addr, in, 16: CPU address bus.
- rw, in, 1: 1 = read, 0 = write.
- dbo, out, 8: read data toward the CPU.
- sel, out, 1: high when dbo must drive the CPU data bus.

Behaviour:
- Reset values:
  - strobe = 0, akd = 0, ascii = 0x00, state = IDLE, counters = 0.
  - dbo = 0x00, sel = 0.
- Input conditioning:
  - keycode passes through a 2-flop synchronizer (kc_s).
  - A stability counter reloads on any change of kc_s.
  - When the counter reaches STABLE_CYCLES, kc_st := kc_s and a one-clk "kc_valid" pulse fires.
  - Total acceptance latency from a keycode change = 2 + STABLE_CYCLES clk.
- Translation (combinational, HID → ASCII):
  - 0x04–0x1D → 0x41–0x5A ('A'–'Z').
  - 0x1E–0x26 → 0x31–0x39; 0x27 → 0x30.
  - 0x28 → 0x0D; 0x29 → 0x1B; 0x2A → 0x08; 0x2B → 0x09; 0x2C → 0x20.
  - 0x4F → 0x15; 0x50 → 0x08; 0x51 → 0x0A; 0x52 → 0x0B.
  - Any other code is unmapped.
- FSM (evaluated on kc_valid and counter terminal counts):
  - IDLE: mapped nonzero kc_st → ascii := translated code, strobe := 1, akd := 1, repeat counter := 0, go HELD. Unmapped code → stay IDLE, no change.
  - HELD: kc_st = 0 → akd := 0, go IDLE; ascii and strobe are retained. A different mapped kc_st (rollover) → behaves as a fresh press, counter reloads. Counter reaching REPEAT_DELAY_CYCLES → strobe := 1, counter := 0, go REPEAT.
  - REPEAT: counter reaching REPEAT_PERIOD_CYCLES → strobe := 1, counter := 0. Release and rollover are handled exactly as in HELD.
- Bus, with dbo and sel combinational from registers and addr/rw:
  - Read of $C000–$C00F: sel = 1, dbo = {strobe, ascii[6:0]}.
  - Read of $C010–$C01F: sel = 1, dbo = {akd, ascii[6:0]}.
  - Otherwise sel = 0, dbo = 0x00.
  - Any access (read or write) to $C010–$C01F with bus_en = 1 clears strobe on that clk edge. The value read in that cycle is the pre-clear value.
- Simultaneous set and clear: if a strobe set (press, rollover or repeat) coincides with a KBDSTRB clear, the set wins and strobe stays 1. No keypress may be lost.
- Counter width: ceil(log2(max parameter + 1)); counters saturate, never wrap.
- Reset asserted mid-hold: all state returns to reset values. After release, a still-held key is re-accepted as a new press after 2 + STABLE_CYCLES clk.

Optional Feature:
- KB_REPEAT_EN defined: typematic repeat as above (HELD → REPEAT path).
- KB_REPEAT_EN undefined:
  - The repeat counter and REPEAT state are removed.
  - HELD waits only for release or rollover.
  - Holding a key sets strobe exactly once.

Test Plan:
(All cases use STABLE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=10.)
- Press and read: keycode=0x04 held → after 6 clk, read $C000 returns 0xC1; bus_en write to $C010 → next read of $C000 returns 0x41, read of $C010 returns 0xC1.
- Glitch and unmapped codes: keycode 0x05 for 3 clk then 0x00 → strobe stays 0; keycode=0x3A (F1) held → strobe stays 0, akd stays 0.
- Typematic repeat (KB_REPEAT_EN): hold 0x2C, clearing strobe via $C010 after each set → strobe re-sets 20 clk after acceptance, then every 10 clk; $C000 reads 0xA0.
- Repeat compiled out (no KB_REPEAT_EN): same stimulus → strobe sets exactly once.
- Rollover and release: 0x04 held, then 0x05 → ascii becomes 0x42 and strobe sets. Then keycode=0x00 → read $C010 returns 0x42 (akd = 0) and ascii is retained.
- Collision and reset: repeat set lands in the same clk as a $C010 access → strobe = 1 afterwards. Assert reset mid-REPEAT → dbo = 0x00, sel = 0, strobe = 0 immediately, without waiting for a clk edge.
